// File: rtl/chess_timer.sv
// chess_timer: two-player countdown core of the chess clock.
//
// Each rising edge of the 10 Hz level input clk_10 is one tick of 0.1 s.
// A tick decrements the running player's remaining time. This block also
// runs the turn / pause / timeout state machine and gates the buzzer tone.
//
// Ports
//   clk_50m    in   system clock
//   rst_n      in   asynchronous active-low reset
//   clk_10     in   10 Hz square wave, already in the clk_50m domain
//   clk_763    in   buzzer tone, level input
//   btn_a      in   one-cycle pulse, player A ends move
//   btn_b      in   one-cycle pulse, player B ends move
//   btn_pause  in   one-cycle pulse, pause/resume toggle
//   clr        in   one-cycle pulse, return to IDLE with reload
//   a_left     out  player A remaining time, tenths of a second
//   b_left     out  player B remaining time, tenths of a second
//   active     out  01 = A running, 10 = B running, 00 = none
//   paused     out  high while paused
//   timeout_a  out  A flagged
//   timeout_b  out  B flagged
//   buzzer     out  clk_763 gated by the beep counter
module chess_timer #(
    parameter int INIT_SEC     = 300,
    parameter int BEEP_SWITCH  = 2,
    parameter int BEEP_TIMEOUT = 20
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic        clk_10,
    input  logic        clk_763,
    input  logic        btn_a,
    input  logic        btn_b,
    input  logic        btn_pause,
    input  logic        clr,
    output logic [15:0] a_left,
    output logic [15:0] b_left,
    output logic [1:0]  active,
    output logic        paused,
    output logic        timeout_a,
    output logic        timeout_b,
    output logic        buzzer
);

    localparam logic [15:0] RELOAD  = 16'(INIT_SEC * 10);
    localparam logic [15:0] BEEP_SW = 16'(BEEP_SWITCH);
    localparam logic [15:0] BEEP_TO = 16'(BEEP_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_A,
        S_RUN_B,
        S_PAUSED,
        S_TIMEOUT
    } state_t;

    state_t      state_q;
    logic        resume_b_q;   // side to resume after PAUSED: 0 = A, 1 = B
    logic        clk10_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] beep_q;
    logic [1:0]  active_q;
    logic        paused_q;
    logic        timeout_a_q;
    logic        timeout_b_q;
    logic        tick_d;

    // One tick per clk_10 rising edge. clk10_q resets to 1 so a clk_10
    // that is already high at reset release does not count as an edge.
    assign tick_d = clk_10 & ~clk10_q;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            resume_b_q  <= 1'b0;
            clk10_q     <= 1'b1;
            a_q         <= RELOAD;
            b_q         <= RELOAD;
            beep_q      <= 16'd0;
            active_q    <= 2'b00;
            paused_q    <= 1'b0;
            timeout_a_q <= 1'b0;
            timeout_b_q <= 1'b0;
        end else begin
            clk10_q <= clk_10;

            // Beep countdown runs in every state. Any load below comes
            // later in this block and therefore overwrites it.
            if (tick_d && beep_q != 16'd0) begin
                beep_q <= beep_q - 16'd1;
            end

            if (clr) begin
                state_q     <= S_IDLE;
                resume_b_q  <= 1'b0;
                a_q         <= RELOAD;
                b_q         <= RELOAD;
                beep_q      <= 16'd0;
                active_q    <= 2'b00;
                paused_q    <= 1'b0;
                timeout_a_q <= 1'b0;
                timeout_b_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // The player who presses starts the opponent's clock.
                        if (btn_a && !btn_b) begin
                            state_q  <= S_RUN_B;
                            active_q <= 2'b10;
                        end else if (btn_b && !btn_a) begin
                            state_q  <= S_RUN_A;
                            active_q <= 2'b01;
                        end
                    end

                    S_RUN_A: begin
                        // Running out of time beats every button.
                        if (tick_d && a_q <= 16'd1) begin
                            a_q         <= 16'd0;
                            state_q     <= S_TIMEOUT;
                            timeout_a_q <= 1'b1;
                            active_q    <= 2'b00;
                            beep_q      <= BEEP_TO;
                        end else begin
                            if (tick_d) begin
                                a_q <= a_q - 16'd1;
                            end
                            if (btn_pause) begin
                                state_q    <= S_PAUSED;
                                resume_b_q <= 1'b0;
                                paused_q   <= 1'b1;
                                active_q   <= 2'b00;
                            end else if (btn_a) begin
                                state_q  <= S_RUN_B;
                                active_q <= 2'b10;
                                beep_q   <= BEEP_SW;
                            end
                        end
                    end

                    S_RUN_B: begin
                        if (tick_d && b_q <= 16'd1) begin
                            b_q         <= 16'd0;
                            state_q     <= S_TIMEOUT;
                            timeout_b_q <= 1'b1;
                            active_q    <= 2'b00;
                            beep_q      <= BEEP_TO;
                        end else begin
                            if (tick_d) begin
                                b_q <= b_q - 16'd1;
                            end
                            if (btn_pause) begin
                                state_q    <= S_PAUSED;
                                resume_b_q <= 1'b1;
                                paused_q   <= 1'b1;
                                active_q   <= 2'b00;
                            end else if (btn_b) begin
                                state_q  <= S_RUN_A;
                                active_q <= 2'b01;
                                beep_q   <= BEEP_SW;
                            end
                        end
                    end

                    S_PAUSED: begin
                        if (btn_pause) begin
                            paused_q <= 1'b0;
                            if (resume_b_q) begin
                                state_q  <= S_RUN_B;
                                active_q <= 2'b10;
                            end else begin
                                state_q  <= S_RUN_A;
                                active_q <= 2'b01;
                            end
                        end
                    end

                    S_TIMEOUT: begin
                        // Frozen until clr or reset.
                    end

                    default: begin
                        state_q  <= S_IDLE;
                        active_q <= 2'b00;
                        paused_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign a_left    = a_q;
    assign b_left    = b_q;
    assign active    = active_q;
    assign paused    = paused_q;
    assign timeout_a = timeout_a_q;
    assign timeout_b = timeout_b_q;
    assign buzzer    = clk_763 & (beep_q != 16'd0);

endmodule

// File: tb/tb_chess_timer.sv
// Testbench for chess_timer: directed scenarios followed by random stimulus,
// scored against a behavioural model of the two-player clock.
module tb_chess_timer;

    localparam int INIT_SEC = 3;
    localparam int BSW      = 2;
    localparam int BTO      = 20;
    localparam int RELOAD   = INIT_SEC * 10;

    logic        clk_50m = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_10 = 1'b0;
    logic        clk_763 = 1'b0;
    logic        btn_a = 1'b0;
    logic        btn_b = 1'b0;
    logic        btn_pause = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] a_left;
    logic [15:0] b_left;
    logic [1:0]  active;
    logic        paused;
    logic        timeout_a;
    logic        timeout_b;
    logic        buzzer;

    chess_timer #(
        .INIT_SEC    (INIT_SEC),
        .BEEP_SWITCH (BSW),
        .BEEP_TIMEOUT(BTO)
    ) dut (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .clk_10   (clk_10),
        .clk_763  (clk_763),
        .btn_a    (btn_a),
        .btn_b    (btn_b),
        .btn_pause(btn_pause),
        .clr      (clr),
        .a_left   (a_left),
        .b_left   (b_left),
        .active   (active),
        .paused   (paused),
        .timeout_a(timeout_a),
        .timeout_b(timeout_b),
        .buzzer   (buzzer)
    );

    always #5 clk_50m = ~clk_50m;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  act;
        logic        p;
        logic        ta;
        logic        tb;
        logic        bz;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int n_pass = 0;
    int n_chk  = 0;

    // Model: remaining time per player, whose turn it is (0 none, 1 A, 2 B),
    // whether the clock is paused, who has flagged (0 none), beep ticks left.
    int left[1:2];
    int turn;
    int flagged;
    int beep;
    bit paused_m;
    bit c10_prev;

    int ph = 0;
    int c10_mode = 0;     // 0: period-4 square wave, 1: held high, 2: random
    bit want_rst = 1'b0;

    function automatic void model_reset();
        left[1]  = RELOAD;
        left[2]  = RELOAD;
        turn     = 0;
        flagged  = 0;
        beep     = 0;
        paused_m = 1'b0;
        c10_prev = 1'b1;
    endfunction

    function automatic void model_step(bit rn, bit c10, bit ba, bit bb, bit bp, bit bc);
        bit tick;
        bit own;
        int load;
        int p;
        if (!rn) begin
            model_reset();
            return;
        end
        tick = c10 && !c10_prev;
        if (bc) begin
            model_reset();
            c10_prev = c10;
            return;
        end
        c10_prev = c10;
        load = -1;
        if (flagged != 0) begin
            // clock frozen after a flag
        end else if (turn == 0) begin
            if (ba && !bb) turn = 2;
            else if (bb && !ba) turn = 1;
        end else if (paused_m) begin
            if (bp) paused_m = 1'b0;
        end else begin
            p = turn;
            own = (p == 1) ? ba : bb;
            if (tick) begin
                if (left[p] <= 1) begin
                    left[p] = 0;
                    flagged = p;
                    load = BTO;
                end else begin
                    left[p] = left[p] - 1;
                end
            end
            if (flagged == 0) begin
                if (bp) paused_m = 1'b1;
                else if (own) begin
                    turn = 3 - p;
                    load = BSW;
                end
            end
        end
        if (tick && beep > 0) beep = beep - 1;
        if (load >= 0) beep = load;
    endfunction

    function automatic exp_t model_out(bit c763);
        exp_t e;
        e.a   = 16'(left[1]);
        e.b   = 16'(left[2]);
        e.act = 2'b00;
        if (turn != 0 && !paused_m && flagged == 0) e.act = (turn == 1) ? 2'b01 : 2'b10;
        e.p   = paused_m;
        e.ta  = (flagged == 1);
        e.tb  = (flagged == 2);
        e.bz  = c763 && (beep != 0);
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int ex);
        n_chk++;
        if (act == ex) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, ex, $time);
    endtask

    task automatic cmp_all(input exp_t e);
        chk("a_left", int'(a_left), int'(e.a));
        chk("b_left", int'(b_left), int'(e.b));
        chk("active", int'(active), int'(e.act));
        chk("paused", int'(paused), int'(e.p));
        chk("timeout_a", int'(timeout_a), int'(e.ta));
        chk("timeout_b", int'(timeout_b), int'(e.tb));
        chk("buzzer", int'(buzzer), int'(e.bz));
    endtask

    // Monitor: one expected response per clock edge, compared after the edge.
    initial begin
        forever begin
            @(posedge clk_50m);
            #1;
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                cmp_all(mon_e);
            end
        end
    end

    task automatic step(input bit ba, input bit bb, input bit bp, input bit bc);
        @(negedge clk_50m);
        rst_n = want_rst;
        case (c10_mode)
            0:       clk_10 = ((ph % 4) < 2);
            1:       clk_10 = 1'b1;
            default: clk_10 = 1'($urandom_range(0, 1));
        endcase
        ph++;
        clk_763   = 1'($urandom_range(0, 1));
        btn_a     = ba;
        btn_b     = bb;
        btn_pause = bp;
        clr       = bc;
        model_step(want_rst, clk_10, ba, bb, bp, bc);
        q.push_back(model_out(clk_763));
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance so that the next step() drives the clk_10 rising edge.
    task automatic align();
        while ((ph % 4) != 0) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            align();
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        model_reset();
        q.push_back(model_out(1'b0));

        // Reset held while clk_10 toggles, then idle: nothing counts down.
        want_rst = 1'b0;
        c10_mode = 0;
        run(3);
        want_rst = 1'b1;
        run(12);

        // B starts A's clock, five ticks, then A hands over with a short beep.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(4);
        run(3);

        // Pause in RUN_B across ten ticks, then resume.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(10);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(2);

        // Both buttons together in IDLE.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        ticks(2);

        // A runs down to 1, then btn_a lands on the final tick.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        while (left[1] > 1) ticks(1);
        align();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (22) begin
            align();
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end

        // clr out of TIMEOUT.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        run(4);

        // Asynchronous reset mid-run with A at 17, clk_10 held high.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        while (left[1] > 17) ticks(1);
        c10_mode = 1;
        run(3);
        @(posedge clk_50m);
        #3;
        want_rst = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        cmp_all(model_out(clk_763));
        run(3);
        want_rst = 1'b1;
        run(6);
        c10_mode = 0;
        run(8);

        // Random buttons and random clk_10 levels.
        c10_mode = 2;
        repeat (1500) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
        end

        run(2);
        @(posedge clk_50m);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/chess_timer.md
Name: chess_timer

Overview:
- Two-player countdown core of the chess clock.
- Consumes the divider's 10 Hz square wave (clk_10) and buzzer tone (clk_763), both registered in the clk_50m domain.
- Turns clk_10 rising edges into decrements of the active player's remaining time.
- Runs the turn/pause/timeout state machine and gates the tone into a buzzer output. Display formatting lives downstream.

Parameters:
- INIT_SEC, 300: starting time per player in seconds. Reload value is INIT_SEC*10 tenths; must be ≤ 6553.
- BEEP_SWITCH, 2: buzzer duration in ticks after a turn switch.
- BEEP_TIMEOUT, 20: buzzer duration in ticks after a timeout.

Ports:
- clk_50m  in  1  system clock, 50 MHz
- rst_n  in  1  reset
- clk_10  in  1  10 Hz square wave from the divider; level input, same clock domain
- clk_763  in  1  buzzer tone from the divider; level input
- btn_a  in  1  one-cycle pulse, player A ends move (debounced upstream)
- btn_b  in  1  one-cycle pulse, player B ends move
- btn_pause  in  1  one-cycle pulse, pause/resume toggle
- clr  in  1  one-cycle pulse, synchronous return to IDLE with reload
- a_left  out  16  player A remaining time in tenths of a second
- b_left  out  16  player B remaining time in tenths of a second
- active  out  2  01 = A running, 10 = B running, 00 = none
- paused  out  1  high in PAUSED
- timeout_a  out  1  A flagged
- timeout_b  out  1  B flagged
- buzzer  out  1  clk_763 AND beep_active

Behaviour:
- Clock and reset: one clock, clk_50m; reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE
  - a_left = b_left = INIT_SEC*10
  - active = 00, paused = 0, timeout_a = timeout_b = 0
  - beep counter = 0, buzzer = 0
  - clk_10 edge register = 1, so no spurious tick if clk_10 is high at release.
- Tick: tick = clk_10 & ~clk_10_d, where clk_10_d is clk_10 registered.
  - Exactly one tick per clk_10 rising edge.
  - The counter update is visible on a_left/b_left one clk_50m cycle after clk_10 is first sampled high.
- Priority each cycle: clr > FSM event handling. clr reloads both counters, clears all flags and the beep counter, and goes to IDLE from any state.
- IDLE:
  - Ticks are ignored.
  - btn_a alone → RUN_B (A presses, starting B's clock).
  - btn_b alone → RUN_A.
  - btn_a and btn_b in the same cycle → stay IDLE.
  - btn_pause is ignored.
  - No beep on leaving IDLE.
- RUN_A (active = 01):
  - On tick, a_left decrements by 1.
  - If a_left == 1 at the tick: a_left becomes 0, go to TIMEOUT, timeout_a = 1, beep counter loads BEEP_TIMEOUT.
  - btn_a → RUN_B and beep counter loads BEEP_SWITCH.
  - btn_b is ignored.
  - btn_pause → PAUSED, resume side saved as A.
- RUN_B: mirror of RUN_A with roles swapped.
- Simultaneous events in RUN_x:
  - The tick is applied to the running player before the switch.
  - Tick-to-zero beats btn_x: TIMEOUT, no switch.
  - btn_pause together with btn_x: pause wins, no switch, resume side = current side. The same-cycle tick still decrements.
- PAUSED (paused = 1, active = 00):
  - Ticks, btn_a and btn_b are ignored.
  - btn_pause → saved RUN state, no beep.
- TIMEOUT:
  - Counters are frozen and active = 00.
  - timeout_x is held.
  - All buttons except clr are ignored.
- Beep counter:
  - Decrements by 1 per tick while nonzero, in any state.
  - beep_active = (counter != 0).
  - A new load overwrites any remaining count.
- Arithmetic: a_left and b_left are unsigned 16-bit, never decrement below 0, no wrap.

Test Plan:
- INIT_SEC = 3, reset, then clk_10 running → a_left = b_left = 30, active = 00, no decrements, buzzer = 0.
- btn_b, then 5 clk_10 rising edges → active = 01, a_left = 25, b_left = 30. Then btn_a → active = 10, buzzer follows clk_763 for exactly 2 ticks and then stays 0.
- In RUN_A with a_left = 1, drive btn_a in the same cycle as the tick → a_left = 0, timeout_a = 1, active = 00, no switch, buzzer gated for 20 ticks; further btn_b and btn_pause have no effect.
- In RUN_B, btn_pause, then 10 ticks, then btn_pause → b_left unchanged across the pause, paused high only during PAUSED, resumes with active = 10.
- Hold clk_10 high across reset release, and assert rst_n low mid-run with a_left = 17 → no tick at release; async reset restores 30/30, IDLE, buzzer = 0 immediately.
- btn_a and btn_b in the same cycle in IDLE → stays IDLE. clr during TIMEOUT → IDLE, both counters = 30, flags cleared.
